laser_chase_sequencer: RTL and testbench
========================================

Name: laser_chase_sequencer

Overview:
Per-frame motion scheduler placed after the red-dot detector. It consumes the 2-bit {left,right} detection result, strobed once per camera frame, and turns it into debounced motor commands. Commands go to the motor driver over a valid/ready handshake. A watchdog forces STOP if frames stop arriving.

Parameters:
CONFIRM_FRAMES, 3, consecutive identical non-zero detections needed to enter CHASE (range 1..15)
LOST_FRAMES, 8, consecutive 00 detections in CHASE before returning to SEARCH (range 1..255)
STEP_CYCLES, 16'd49152, duration field attached to every move command
WATCHDOG_CYCLES, 24'd4915200, cycles without frame_strobe_in before forced STOP (about 50 ms at 98.304 MHz)

Ports:
clk_in  input  1  system clock (98.304 MHz pixel clock)
rst_n_in  input  1  reset, asynchronous assert, active-low
enable_in  input  1  level; 0 forces IDLE
frame_strobe_in  input  1  one-cycle pulse; detected_in is valid this cycle
detected_in  input  2  {left_hit,right_hit} for the last frame
cmd_ready_in  input  1  motor driver accepts the command
cmd_valid_out  output  1  command available
cmd_dir_out  output  2  0 STOP, 1 LEFT, 2 RIGHT, 3 FORWARD
cmd_duration_out  output  16  0 for STOP, STEP_CYCLES otherwise
state_out  output  3  current FSM state encoding
stale_out  output  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset values: state IDLE, cmd_valid_out 0, cmd_dir_out 0, cmd_duration_out 0, stale_out 0, all counters 0. Reset mid-handshake discards any pending command.
- States: IDLE=0, SEARCH=1, CONFIRM=2, CHASE=3.
- IDLE:
  - On entry from any state except reset, enqueue STOP.
  - enable_in=1 moves to SEARCH on the next cycle.
- enable_in=0 in any state: next state IDLE, with the highest priority.
- SEARCH: on a strobe with detected_in≠00, latch cand=detected_in, set conf_cnt=1, go to CONFIRM. If CONFIRM_FRAMES==1, go directly to CHASE and emit that frame's command.
- CONFIRM, on each strobe:
  - detected_in==cand: conf_cnt++. When it reaches CONFIRM_FRAMES, go to CHASE and enqueue the move for cand.
  - 00: go to SEARCH.
  - Another non-zero pattern: cand=new pattern, conf_cnt=1.
- CHASE, on each strobe:
  - 10 enqueues LEFT, 01 enqueues RIGHT, 11 enqueues FORWARD. Each clears miss_cnt.
  - 00: miss_cnt++. When it reaches LOST_FRAMES, enqueue STOP and go to SEARCH. Below that, no command is issued (the motor finishes its step).
- Command latency: a command is enqueued in the strobe cycle and appears on the outputs the next cycle if the output register is free.
- Output rules:
  - cmd_* stay stable while cmd_valid_out=1 and cmd_ready_in=0.
  - Transfer happens when valid and ready are both 1.
- Buffering: the output register plus one pending slot, latest-wins.
  - An enqueue while the output is stalled overwrites the pending slot.
  - An enqueue in the same cycle as the transfer goes straight to the output register.
  - The pending slot is promoted the cycle after the transfer.
  - Any STOP enqueue clears a pending move before being written.
- Watchdog:
  - Counter resets on every strobe and while in IDLE.
  - On reaching WATCHDOG_CYCLES-1 in SEARCH, CONFIRM or CHASE: pulse stale_out, enqueue STOP, go to SEARCH, zero the counter.
  - A strobe in the same cycle wins; the watchdog does not fire.
- A strobe arriving while enable_in=0 is ignored.
- All counters saturate and never wrap.

Optional Feature:
LASER_CHASE_SEQUENCER_STATS_EN
- Defined: adds output ports frame_cnt_out[15:0] (strobes seen, wraps at 0xFFFF→0) and drop_cnt_out[15:0] (pending-slot overwrites, saturating). Both are cleared by reset.
- Undefined: these ports and their counters do not exist. Other behaviour is identical.

Decomposition:
- laser_chaser_pkg:
  - cmd_dir_t enum (STOP/LEFT/RIGHT/FORWARD)
  - seq_state_t enum (IDLE/SEARCH/CONFIRM/CHASE)
  - function det_to_dir(logic [1:0])
- Sub-module cmd_skid_buffer: the output register plus latest-wins pending slot, with the handshake, the STOP-flush input and the drop pulse. The FSM and watchdog stay in the top.

Test Plan:
- Reset, enable=1, strobes 10,10,10 with ready=1 → state CONFIRM after strobes 1–2, CHASE after strobe 3; exactly one LEFT command, duration 49152, valid one cycle after strobe 3.
- In CHASE, strobes 01,11 then eight 00 → RIGHT, then FORWARD, then STOP on the 8th miss; state returns to SEARCH.
- CONFIRM with 10,01,01,01 → candidate switches; CHASE entered on the 4th strobe with RIGHT.
- ready held 0, CHASE strobes 10,01,11 → output holds LEFT; pending ends as FORWARD (RIGHT dropped, drop_cnt_out=1 with STATS_EN); after ready, LEFT then FORWARD transfer.
- CHASE, no strobes for 4915200 cycles → stale_out pulses once, STOP enqueued, state SEARCH; a strobe in the firing cycle suppresses it.
- enable_in deasserted mid-stall → pending move flushed, STOP queued behind the held command, state IDLE; rst_n_in low mid-handshake → cmd_valid_out 0 immediately (asynchronous).

Source files
------------

// File: rtl/laser_chaser_pkg.sv
// Shared types for the laser chase sequencer: motor command directions,
// sequencer states and the detection-to-direction mapping.
package laser_chaser_pkg;

  typedef enum logic [1:0] {
    CMD_STOP    = 2'd0,
    CMD_LEFT    = 2'd1,
    CMD_RIGHT   = 2'd2,
    CMD_FORWARD = 2'd3
  } cmd_dir_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEARCH  = 3'd1,
    ST_CONFIRM = 3'd2,
    ST_CHASE   = 3'd3
  } seq_state_t;

  // detected is {left_hit, right_hit}
  function automatic cmd_dir_t det_to_dir(input logic [1:0] det);
    case (det)
      2'b10:   return CMD_LEFT;
      2'b01:   return CMD_RIGHT;
      2'b11:   return CMD_FORWARD;
      default: return CMD_STOP;
    endcase
  endfunction

endpackage

// File: rtl/cmd_skid_buffer.sv
// Motor command output register plus one latest-wins pending slot, with the
// valid/ready handshake toward the motor driver.
module cmd_skid_buffer
  import laser_chaser_pkg::*;
#(
  parameter logic [15:0] STEP_CYCLES = 16'd49152
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enq_valid_i,
  input  cmd_dir_t    enq_dir_i,
  input  logic        enq_flush_i,
  input  logic        ready_i,
  output logic        valid_o,
  output cmd_dir_t    dir_o,
  output logic [15:0] duration_o,
  output logic        drop_o
);

  logic        out_valid_q, out_valid_d;
  cmd_dir_t    out_dir_q, out_dir_d;
  logic [15:0] out_dur_q, out_dur_d;
  logic        pend_valid_q, pend_valid_d;
  cmd_dir_t    pend_dir_q, pend_dir_d;
  logic        xfer;

  function automatic logic [15:0] dur_of(input cmd_dir_t d);
    return (d == CMD_STOP) ? 16'd0 : STEP_CYCLES;
  endfunction

  always_comb begin
    xfer         = out_valid_q & ready_i;
    out_valid_d  = out_valid_q;
    out_dir_d    = out_dir_q;
    out_dur_d    = out_dur_q;
    pend_valid_d = pend_valid_q;
    pend_dir_d   = pend_dir_q;

    if (!out_valid_q || xfer) begin
      // A fresh enqueue is newer than anything pending, so it takes the
      // output register directly and the pending entry is discarded.
      if (enq_valid_i) begin
        out_valid_d  = 1'b1;
        out_dir_d    = enq_dir_i;
        out_dur_d    = dur_of(enq_dir_i);
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        out_valid_d  = 1'b1;
        out_dir_d    = pend_dir_q;
        out_dur_d    = dur_of(pend_dir_q);
        pend_valid_d = 1'b0;
      end else begin
        out_valid_d  = 1'b0;
      end
    end else if (enq_valid_i) begin
      pend_valid_d = 1'b1;
      pend_dir_d   = enq_dir_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_q  <= 1'b0;
      out_dir_q    <= CMD_STOP;
      out_dur_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_dir_q   <= CMD_STOP;
    end else begin
      out_valid_q  <= out_valid_d;
      out_dir_q    <= out_dir_d;
      out_dur_q    <= out_dur_d;
      pend_valid_q <= pend_valid_d;
      pend_dir_q   <= pend_dir_d;
    end
  end

  // A STOP flushes a pending move by design, so only move-over-entry losses count.
  assign drop_o     = enq_valid_i & pend_valid_q & ~enq_flush_i;
  assign valid_o    = out_valid_q;
  assign dir_o      = out_dir_q;
  assign duration_o = out_dur_q;

endmodule

// File: rtl/laser_chase_sequencer.sv
// Per-frame motion scheduler: debounces red-dot detections into motor commands
// with a frame watchdog. Optional stats ports: LASER_CHASE_SEQUENCER_STATS_EN.
module laser_chase_sequencer
  import laser_chaser_pkg::*;
#(
  parameter int unsigned CONFIRM_FRAMES  = 3,
  parameter int unsigned LOST_FRAMES     = 8,
  parameter logic [15:0] STEP_CYCLES     = 16'd49152,
  parameter logic [23:0] WATCHDOG_CYCLES = 24'd4915200
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        enable_in,
  input  logic        frame_strobe_in,
  input  logic [1:0]  detected_in,
  input  logic        cmd_ready_in,
  output logic        cmd_valid_out,
  output logic [1:0]  cmd_dir_out,
  output logic [15:0] cmd_duration_out,
  output logic [2:0]  state_out,
  output logic        stale_out
`ifdef LASER_CHASE_SEQUENCER_STATS_EN
  ,
  output logic [15:0] frame_cnt_out,
  output logic [15:0] drop_cnt_out
`endif
);

  localparam logic [3:0]  CONF_TGT = 4'(CONFIRM_FRAMES);
  localparam logic [7:0]  LOST_TGT = 8'(LOST_FRAMES);
  localparam logic [23:0] WD_LAST  = WATCHDOG_CYCLES - 24'd1;

  seq_state_t  state_q, state_d;
  logic [1:0]  cand_q, cand_d;
  logic [3:0]  conf_q, conf_d, conf_inc;
  logic [7:0]  miss_q, miss_d, miss_inc;
  logic [23:0] wd_q, wd_d, wd_inc;
  logic        stale_q, stale_d;
  logic        enq_valid;
  cmd_dir_t    enq_dir;
  cmd_dir_t    out_dir;

  always_comb begin
    conf_inc  = (conf_q == '1) ? conf_q : conf_q + 4'd1;
    miss_inc  = (miss_q == '1) ? miss_q : miss_q + 8'd1;
    wd_inc    = (wd_q == '1) ? wd_q : wd_q + 24'd1;
    state_d   = state_q;
    cand_d    = cand_q;
    conf_d    = conf_q;
    miss_d    = miss_q;
    wd_d      = wd_q;
    stale_d   = 1'b0;
    enq_valid = 1'b0;
    enq_dir   = CMD_STOP;

    if (!enable_in) begin
      state_d   = ST_IDLE;
      wd_d      = '0;
      conf_d    = '0;
      miss_d    = '0;
      enq_valid = (state_q != ST_IDLE);
    end else if (state_q == ST_IDLE) begin
      state_d = ST_SEARCH;
      wd_d    = '0;
    end else if (frame_strobe_in) begin
      wd_d = '0;
      case (state_q)
        ST_SEARCH: begin
          if (detected_in != 2'b00) begin
            cand_d = detected_in;
            conf_d = 4'd1;
            if (CONF_TGT <= 4'd1) begin
              state_d   = ST_CHASE;
              miss_d    = '0;
              enq_valid = 1'b1;
              enq_dir   = det_to_dir(detected_in);
            end else begin
              state_d = ST_CONFIRM;
            end
          end
        end
        ST_CONFIRM: begin
          if (detected_in == 2'b00) begin
            state_d = ST_SEARCH;
            conf_d  = '0;
          end else if (detected_in == cand_q) begin
            conf_d = conf_inc;
            if (conf_inc >= CONF_TGT) begin
              state_d   = ST_CHASE;
              miss_d    = '0;
              enq_valid = 1'b1;
              enq_dir   = det_to_dir(cand_q);
            end
          end else begin
            cand_d = detected_in;
            conf_d = 4'd1;
          end
        end
        ST_CHASE: begin
          if (detected_in != 2'b00) begin
            miss_d    = '0;
            enq_valid = 1'b1;
            enq_dir   = det_to_dir(detected_in);
          end else if (miss_inc >= LOST_TGT) begin
            miss_d    = '0;
            state_d   = ST_SEARCH;
            enq_valid = 1'b1;
          end else begin
            miss_d = miss_inc;
          end
        end
        default: ;
      endcase
    end else if (wd_q >= WD_LAST) begin
      stale_d   = 1'b1;
      enq_valid = 1'b1;
      state_d   = ST_SEARCH;
      wd_d      = '0;
      conf_d    = '0;
      miss_d    = '0;
    end else begin
      wd_d = wd_inc;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      conf_q  <= '0;
      miss_q  <= '0;
      wd_q    <= '0;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      conf_q  <= conf_d;
      miss_q  <= miss_d;
      wd_q    <= wd_d;
      stale_q <= stale_d;
    end
  end

`ifdef LASER_CHASE_SEQUENCER_STATS_EN
  logic skid_drop;
`endif

  cmd_skid_buffer #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_skid (
    .clk_i       (clk_in),
    .rst_n_i     (rst_n_in),
    .enq_valid_i (enq_valid),
    .enq_dir_i   (enq_dir),
    .enq_flush_i (enq_valid && (enq_dir == CMD_STOP)),
    .ready_i     (cmd_ready_in),
    .valid_o     (cmd_valid_out),
    .dir_o       (out_dir),
    .duration_o  (cmd_duration_out),
`ifdef LASER_CHASE_SEQUENCER_STATS_EN
    .drop_o      (skid_drop)
`else
    .drop_o      ()
`endif
  );

`ifdef LASER_CHASE_SEQUENCER_STATS_EN
  logic [15:0] frame_cnt_q, drop_cnt_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (frame_strobe_in && enable_in) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (skid_drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign frame_cnt_out = frame_cnt_q;
  assign drop_cnt_out  = drop_cnt_q;
`endif

  assign cmd_dir_out = out_dir;
  assign state_out   = state_q;
  assign stale_out   = stale_q;

endmodule

// File: tb/tb_laser_chase_sequencer.sv
// Self-checking bench for laser_chase_sequencer: directed scenarios with literal
// expectations plus randomized traffic compared to a behavioural model.
module tb_laser_chase_sequencer;

  localparam int unsigned CF   = 3;
  localparam int unsigned LF   = 8;
  localparam int          W    = 300;
  localparam int          STEP = 49152;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        strobe = 1'b0;
  logic [1:0]  det = 2'b00;
  logic        ready = 1'b0;
  logic        cmd_valid_out;
  logic [1:0]  cmd_dir_out;
  logic [15:0] cmd_duration_out;
  logic [2:0]  state_out;
  logic        stale_out;
`ifdef LASER_CHASE_SEQUENCER_STATS_EN
  logic [15:0] frame_cnt_out;
  logic [15:0] drop_cnt_out;
`endif

  always #5 clk = ~clk;

  laser_chase_sequencer #(
    .CONFIRM_FRAMES  (CF),
    .LOST_FRAMES     (LF),
    .STEP_CYCLES     (16'd49152),
    .WATCHDOG_CYCLES (24'(W))
  ) dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .enable_in        (enable),
    .frame_strobe_in  (strobe),
    .detected_in      (det),
    .cmd_ready_in     (ready),
    .cmd_valid_out    (cmd_valid_out),
    .cmd_dir_out      (cmd_dir_out),
    .cmd_duration_out (cmd_duration_out),
    .state_out        (state_out),
    .stale_out        (stale_out)
`ifdef LASER_CHASE_SEQUENCER_STATS_EN
    ,
    .frame_cnt_out    (frame_cnt_out),
    .drop_cnt_out     (drop_cnt_out)
`endif
  );

  int checks = 0;
  int failures = 0;
  int stale_seen = 0;
  int xlog[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int xat(input int i);
    return (i < xlog.size()) ? xlog[i] : -1;
  endfunction

  // Behavioural model: states 0..3, command list where entry 0 is on the outputs
  // and at most one newer entry waits behind it.
  int m_state, m_cand, m_conf, m_miss, m_wd, m_stale;
  int mq[$];
  int md_cmd, md_ns;
  bit md_xfer;
  int dirmap [4] = '{0, 2, 1, 3};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_cand = 0; m_conf = 0; m_miss = 0; m_wd = 0; m_stale = 0;
      mq.delete();
    end else begin
      md_cmd  = -1;
      md_ns   = m_state;
      m_stale = 0;
      if (!enable) begin
        if (m_state != 0) md_cmd = 0;
        md_ns = 0; m_wd = 0; m_conf = 0; m_miss = 0;
      end else if (m_state == 0) begin
        md_ns = 1; m_wd = 0;
      end else if (strobe) begin
        m_wd = 0;
        if (m_state == 1) begin
          if (det != 0) begin
            m_cand = int'(det); m_conf = 1;
            if (CF == 1) begin md_ns = 3; m_miss = 0; md_cmd = dirmap[det]; end
            else md_ns = 2;
          end
        end else if (m_state == 2) begin
          if (det == 0) md_ns = 1;
          else if (int'(det) == m_cand) begin
            m_conf++;
            if (m_conf >= int'(CF)) begin md_ns = 3; m_miss = 0; md_cmd = dirmap[m_cand]; end
          end else begin
            m_cand = int'(det); m_conf = 1;
          end
        end else begin
          if (det != 0) begin md_cmd = dirmap[det]; m_miss = 0; end
          else begin
            m_miss++;
            if (m_miss >= int'(LF)) begin md_cmd = 0; md_ns = 1; m_miss = 0; end
          end
        end
      end else if (m_wd == W - 1) begin
        m_stale = 1; md_cmd = 0; md_ns = 1; m_wd = 0;
      end else begin
        m_wd++;
      end
      m_state = md_ns;

      md_xfer = (mq.size() > 0) && ready;
      if (md_xfer) void'(mq.pop_front());
      if (md_cmd >= 0) begin
        if (md_xfer || mq.size() == 0) begin
          mq.delete();
          mq.push_back(md_cmd);
        end else begin
          while (mq.size() > 1) void'(mq.pop_back());
          mq.push_back(md_cmd);
        end
      end
    end
  end

  // Transfer log taken from the DUT handshake (pre-edge values).
  always @(posedge clk) begin
    if (rst_n && cmd_valid_out && ready) xlog.push_back(int'(cmd_dir_out));
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("state", int'(state_out), m_state);
      check("valid", int'(cmd_valid_out), int'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("dir", int'(cmd_dir_out), mq[0]);
        check("duration", int'(cmd_duration_out), (mq[0] == 0) ? 0 : STEP);
      end
      check("stale", int'(stale_out), m_stale);
      if (stale_out) stale_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [1:0] d);
    det = d;
    strobe = 1'b1;
    tick(1);
    strobe = 1'b0;
    det = 2'b00;
  endtask

  int base, s0, quiet;
  logic [1:0] last_det;

  initial begin
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("rst_state", int'(state_out), 0);
    check("rst_valid", int'(cmd_valid_out), 0);
    check("rst_dir", int'(cmd_dir_out), 0);
    check("rst_dur", int'(cmd_duration_out), 0);
    check("rst_stale", int'(stale_out), 0);

    // confirm three LEFT frames
    enable = 1'b1; ready = 1'b1;
    tick(1);
    check("t1_search", int'(state_out), 1);
    base = xlog.size();
    pulse(2'b10); check("t1_conf1", int'(state_out), 2); tick(2);
    pulse(2'b10); check("t1_conf2", int'(state_out), 2); tick(2);
    pulse(2'b10);
    check("t1_chase", int'(state_out), 3);
    check("t1_valid", int'(cmd_valid_out), 1);
    check("t1_dir", int'(cmd_dir_out), 1);
    check("t1_dur", int'(cmd_duration_out), 49152);
    tick(3);
    check("t1_nxfer", xlog.size() - base, 1);
    check("t1_xdir", xat(base), 1);

    // chase moves then loss
    base = xlog.size();
    pulse(2'b01); tick(3);
    pulse(2'b11); tick(3);
    for (int i = 0; i < 8; i++) begin
      pulse(2'b00);
      if (i == 6) check("t2_still_chase", int'(state_out), 3);
      tick(2);
    end
    check("t2_search", int'(state_out), 1);
    check("t2_nxfer", xlog.size() - base, 3);
    check("t2_x0", xat(base), 2);
    check("t2_x1", xat(base + 1), 3);
    check("t2_x2", xat(base + 2), 0);

    // candidate switch
    pulse(2'b10); check("t3_conf", int'(state_out), 2); tick(2);
    pulse(2'b01); check("t3_switch", int'(state_out), 2); tick(2);
    pulse(2'b01); check("t3_conf2", int'(state_out), 2); tick(2);
    pulse(2'b01);
    check("t3_chase", int'(state_out), 3);
    check("t3_dir", int'(cmd_dir_out), 2);
    tick(3);

    // stalled output, latest-wins pending
    ready = 1'b0;
    pulse(2'b10); tick(2);
    pulse(2'b01); tick(2);
    pulse(2'b11); tick(2);
    check("t4_hold_valid", int'(cmd_valid_out), 1);
    check("t4_hold_dir", int'(cmd_dir_out), 1);
`ifdef LASER_CHASE_SEQUENCER_STATS_EN
    check("t4_drop_cnt", int'(drop_cnt_out), 1);
`endif
    base = xlog.size();
    ready = 1'b1;
    tick(4);
    check("t4_nxfer", xlog.size() - base, 2);
    check("t4_x0", xat(base), 1);
    check("t4_x1", xat(base + 1), 3);

    // watchdog fires once
    base = xlog.size();
    s0 = stale_seen;
    tick(W + 20);
    check("t5_stale_once", stale_seen - s0, 1);
    check("t5_search", int'(state_out), 1);
    check("t5_nxfer", xlog.size() - base, 1);
    check("t5_stop", xat(base), 0);

    // strobe in the firing cycle suppresses the watchdog
    pulse(2'b10); tick(2);
    pulse(2'b10); tick(2);
    pulse(2'b10);
    check("t5b_chase", int'(state_out), 3);
    s0 = stale_seen;
    tick(W - 1);
    pulse(2'b10);
    tick(5);
    check("t5b_no_stale", stale_seen - s0, 0);
    check("t5b_state", int'(state_out), 3);

    // disable mid-stall
    ready = 1'b0;
    pulse(2'b10); tick(2);
    pulse(2'b01); tick(2);
    enable = 1'b0;
    tick(1);
    check("t6_idle", int'(state_out), 0);
    check("t6_hold_dir", int'(cmd_dir_out), 1);
    base = xlog.size();
    ready = 1'b1;
    tick(4);
    check("t6_nxfer", xlog.size() - base, 2);
    check("t6_x0", xat(base), 1);
    check("t6_x1", xat(base + 1), 0);
    check("t6_valid", int'(cmd_valid_out), 0);

    // asynchronous reset mid-handshake
    enable = 1'b1; ready = 1'b0;
    tick(1);
    pulse(2'b10); tick(1);
    pulse(2'b10); tick(1);
    pulse(2'b10);
    check("t7_valid_before", int'(cmd_valid_out), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_async_valid", int'(cmd_valid_out), 0);
    check("t7_async_state", int'(state_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check("t7_after_valid", int'(cmd_valid_out), 0);

    // randomized traffic against the model
    quiet = 0;
    last_det = 2'b10;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
      end
      if (quiet > 0) quiet--;
      else if ($urandom_range(0, 299) == 0) quiet = W + 50;
      enable = (quiet > 0) || ($urandom_range(0, 99) < 97);
      strobe = (quiet == 0) && ($urandom_range(0, 99) < 35);
      if ($urandom_range(0, 2) == 0) last_det = 2'($urandom_range(0, 3));
      det = last_det;
      ready = ($urandom_range(0, 99) < 70);
      tick(1);
    end
    strobe = 1'b0;
    det = 2'b00;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
